// File: rtl/aska_npg_gen2_if.sv
// Configuration and switch/DAC bundle between the SPI register block, the pulse generator and the H-bridge.
// ele_fault is present only when ASKA_NPG_OVERLAP_CHK_EN is defined.
interface aska_npg_gen2_if #(
  parameter int NELEC = 32,
  parameter int AMP_W = 6,
  parameter int PER_W = 12,
  parameter int PH_W  = 3,
  parameter int RF_W  = 10,
  parameter int ON_W  = 8,
  parameter int OFF_W = 10
);
  logic             enable;
  logic [AMP_W-1:0] amplitude;
  logic [PER_W-1:0] period;
  logic [PH_W-1:0]  phase_dur;
  logic [RF_W-1:0]  ramp_factor;
  logic [ON_W-1:0]  on_pulses;
  logic [OFF_W-1:0] off_pulses;
  logic [NELEC-1:0] ele_a;
  logic [NELEC-1:0] ele_b;
  logic [NELEC-1:0] up_switches;
  logic [NELEC-1:0] down_switches;
  logic [AMP_W-1:0] DAC;
  logic             pulse_active;
  logic             burst_on;
`ifdef ASKA_NPG_OVERLAP_CHK_EN
  logic             ele_fault;
`endif

  modport master (
    output enable, amplitude, period, phase_dur, ramp_factor, on_pulses, off_pulses, ele_a, ele_b,
    input  up_switches, down_switches, DAC, pulse_active, burst_on
`ifdef ASKA_NPG_OVERLAP_CHK_EN
    , input ele_fault
`endif
  );

  modport slave (
    input  enable, amplitude, period, phase_dur, ramp_factor, on_pulses, off_pulses, ele_a, ele_b,
    output up_switches, down_switches, DAC, pulse_active, burst_on
`ifdef ASKA_NPG_OVERLAP_CHK_EN
    , output ele_fault
`endif
  );
endinterface

// File: rtl/aska_npg_gen2.sv
// ASKA NPG gen2: charge-balanced biphasic pulses with interphase gap, amplitude ramp and ON/OFF bursts.
// Optional ASKA_NPG_OVERLAP_CHK_EN blanks electrode bits set in both masks and raises ele_fault.
module aska_npg_gen2 #(
  parameter int NELEC   = 32,
  parameter int AMP_W   = 6,
  parameter int PER_W   = 12,
  parameter int PH_W    = 3,
  parameter int PH_UNIT = 1,
  parameter int GAP_CYC = 1,
  parameter int RF_W    = 10,
  parameter int ON_W    = 8,
  parameter int OFF_W   = 10
) (
  input  logic           clk,
  input  logic           resetn,
  aska_npg_gen2_if.slave bus
);
  // state       | meaning
  // IDLE        | outputs quiet, waiting for enable with a usable config
  // BURST_START | one cycle: latch config, clear ramp accumulator and pulse count
  // PH1         | first phase, ele_a high side / ele_b low side
  // GAP         | interphase gap, switches open, pulse still active
  // PH2         | second phase, polarity swapped
  // WAIT        | rest of the pulse period
  // OFF         | silent periods between bursts
  typedef enum logic [2:0] {IDLE, BURST_START, PH1, GAP, PH2, WAIT, OFF} state_t;

  localparam int ACC_W = AMP_W + 4;
  localparam int SUM_W = ((ACC_W > RF_W) ? ACC_W : RF_W) + 1;
  localparam int PHL_W = PH_W + $clog2(PH_UNIT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 2);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t state, state_nxt, after_pulse;

  logic [AMP_W-1:0] amp_r;
  logic [PER_W-1:0] period_r;
  logic [PH_W-1:0]  ph_r;
  logic [RF_W-1:0]  rf_r;
  logic [ON_W-1:0]  on_r;
  logic [OFF_W-1:0] off_r;
  logic [NELEC-1:0] ele_a_r, ele_b_r;

  logic [ACC_W-1:0] acc, acc_sat;
  logic [SUM_W-1:0] acc_sum;
  logic [AMP_W-1:0] level, level_nxt, ramp_lvl;
  logic [PER_W-1:0] per_cnt;
  logic [OFF_W-1:0] off_cnt;
  logic [ON_W-1:0]  pulse_cnt;
  logic [PHL_W-1:0] ph_cnt, ph_len;
  logic [GAP_W-1:0] gap_cnt;
  logic             stop_req;

  logic cfg_ok, per_tc, ph_tc, gap_tc, off_tc, burst_done;
  logic bs_entry, ph1_entry, ph2_entry, gap_entry, off_entry;

  logic [NELEC-1:0] up_nxt, dn_nxt;
  logic [AMP_W-1:0] dac_nxt;
  logic             pa_nxt, bo_nxt;

  assign cfg_ok     = bus.enable && (bus.period != '0) && (bus.phase_dur != '0) && (bus.amplitude != '0);
  assign ph_len     = PHL_W'(ph_r) * PHL_W'(PH_UNIT);
  assign per_tc     = (per_cnt >= period_r - 1'b1);
  assign ph_tc      = (ph_cnt == '0);
  assign gap_tc     = (gap_cnt == '0);
  assign off_tc     = (off_cnt == off_r - 1'b1);
  assign burst_done = (on_r != '0) && (pulse_cnt == on_r);

  assign bs_entry  = (state_nxt == BURST_START);
  assign ph1_entry = (state_nxt == PH1) && (state != PH1);
  assign ph2_entry = (state_nxt == PH2) && (state != PH2);
  assign gap_entry = (state_nxt == GAP) && (state != GAP);
  assign off_entry = (state_nxt == OFF) && (state != OFF);

  // Saturating Q.4 accumulator; ramp_factor of 0 means "full amplitude immediately".
  assign acc_sum   = SUM_W'(acc) + SUM_W'(rf_r);
  assign acc_sat   = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
  assign ramp_lvl  = acc_sat[ACC_W-1:4];
  assign level_nxt = !ph1_entry    ? level :
                     (rf_r == '0)  ? amp_r :
                     (ramp_lvl < amp_r) ? ramp_lvl : amp_r;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    after_pulse = PH1;
    if (burst_done) begin
      if (off_r != '0) after_pulse = OFF;
      else if (cfg_ok) after_pulse = BURST_START;
      else             after_pulse = IDLE;
    end

    state_nxt = state;
    case (state)
      IDLE:        if (cfg_ok) state_nxt = BURST_START;
      BURST_START: state_nxt = bus.enable ? PH1 : IDLE;
      PH1:         if (ph_tc) state_nxt = (GAP_CYC == 0) ? PH2 : GAP;
      GAP:         if (gap_tc) state_nxt = PH2;
      PH2: begin
        // A pulse longer than the period chains straight into the next PH1.
        if (ph_tc) begin
          if (stop_req || !bus.enable) state_nxt = IDLE;
          else if (per_tc)             state_nxt = after_pulse;
          else                         state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!bus.enable)  state_nxt = IDLE;
        else if (per_tc)  state_nxt = after_pulse;
      end
      OFF: begin
        if (!bus.enable)          state_nxt = IDLE;
        else if (per_tc && off_tc) state_nxt = cfg_ok ? BURST_START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    up_nxt  = '0;
    dn_nxt  = '0;
    dac_nxt = '0;
    pa_nxt  = 1'b0;
    bo_nxt  = 1'b0;
    case (state_nxt)
      BURST_START, WAIT: bo_nxt = 1'b1;
      PH1: begin
        up_nxt  = ele_a_r;
        dn_nxt  = ele_b_r;
        dac_nxt = level_nxt;
        pa_nxt  = 1'b1;
        bo_nxt  = 1'b1;
      end
      GAP: begin
        pa_nxt = 1'b1;
        bo_nxt = 1'b1;
      end
      PH2: begin
        up_nxt  = ele_b_r;
        dn_nxt  = ele_a_r;
        dac_nxt = level;
        pa_nxt  = 1'b1;
        bo_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      amp_r      <= '0;
      period_r   <= '0;
      ph_r       <= '0;
      rf_r       <= '0;
      on_r       <= '0;
      off_r      <= '0;
      ele_a_r    <= '0;
      ele_b_r    <= '0;
      acc        <= '0;
      level      <= '0;
      per_cnt    <= '0;
      off_cnt    <= '0;
      pulse_cnt  <= '0;
      ph_cnt     <= '0;
      gap_cnt    <= '0;
      stop_req   <= 1'b0;
`ifdef ASKA_NPG_OVERLAP_CHK_EN
      bus.ele_fault <= 1'b0;
`endif
    end else begin
      if (bs_entry) begin
        amp_r    <= bus.amplitude;
        period_r <= bus.period;
        ph_r     <= bus.phase_dur;
        rf_r     <= bus.ramp_factor;
        on_r     <= bus.on_pulses;
        off_r    <= bus.off_pulses;
`ifdef ASKA_NPG_OVERLAP_CHK_EN
        ele_a_r       <= bus.ele_a & ~bus.ele_b;
        ele_b_r       <= bus.ele_b & ~bus.ele_a;
        bus.ele_fault <= |(bus.ele_a & bus.ele_b);
`else
        ele_a_r  <= bus.ele_a;
        ele_b_r  <= bus.ele_b;
`endif
      end

      if (bs_entry)       acc <= '0;
      else if (ph1_entry) acc <= acc_sat;
      level <= level_nxt;

      if (bs_entry)       pulse_cnt <= '0;
      else if (ph1_entry) pulse_cnt <= pulse_cnt + 1'b1;

      if (ph1_entry || off_entry || (state == OFF && per_tc)) per_cnt <= '0;
      else if (state != IDLE && state != BURST_START)        per_cnt <= per_cnt + 1'b1;

      if (off_entry)                  off_cnt <= '0;
      else if (state == OFF && per_tc) off_cnt <= off_cnt + 1'b1;

      if (ph1_entry || ph2_entry) ph_cnt <= ph_len - 1'b1;
      else if (!ph_tc)            ph_cnt <= ph_cnt - 1'b1;

      if (gap_entry)    gap_cnt <= GAP_LOAD;
      else if (!gap_tc) gap_cnt <= gap_cnt - 1'b1;

      if (state_nxt == IDLE)                                      stop_req <= 1'b0;
      else if ((state == PH1 || state == GAP) && !bus.enable)     stop_req <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.up_switches   <= '0;
      bus.down_switches <= '0;
      bus.DAC           <= '0;
      bus.pulse_active  <= 1'b0;
      bus.burst_on      <= 1'b0;
    end else begin
      bus.up_switches   <= up_nxt;
      bus.down_switches <= dn_nxt;
      bus.DAC           <= dac_nxt;
      bus.pulse_active  <= pa_nxt;
      bus.burst_on      <= bo_nxt;
    end
  end
endmodule

// File: tb/tb_aska_npg_gen2.sv
// Bench for aska_npg_gen2: directed vector table, hand-written corner sequences, randomized configs vs pulse-train model.
// Honors ASKA_NPG_OVERLAP_CHK_EN when defined for the build.
module tb_aska_npg_gen2;
  localparam int NELEC   = 32;
  localparam int AMP_W   = 6;
  localparam int PER_W   = 12;
  localparam int PH_W    = 3;
  localparam int PH_UNIT = 1;
  localparam int GAP_CYC = 1;
  localparam int RF_W    = 10;
  localparam int ON_W    = 8;
  localparam int OFF_W   = 10;
  localparam int ACC_MAX = (1 << (AMP_W + 4)) - 1;

  logic clk = 1'b0;
  logic resetn;

  aska_npg_gen2_if #(.NELEC(NELEC), .AMP_W(AMP_W), .PER_W(PER_W), .PH_W(PH_W),
                     .RF_W(RF_W), .ON_W(ON_W), .OFF_W(OFF_W)) bus();

  aska_npg_gen2 #(.NELEC(NELEC), .AMP_W(AMP_W), .PER_W(PER_W), .PH_W(PH_W), .PH_UNIT(PH_UNIT),
                  .GAP_CYC(GAP_CYC), .RF_W(RF_W), .ON_W(ON_W), .OFF_W(OFF_W))
    dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NELEC-1:0] up;
    logic [NELEC-1:0] dn;
    logic [AMP_W-1:0] dac;
    logic             pa;
    logic             bo;
    logic             flt;
  } obs_t;

  typedef struct {
    int period, ph, amp, rf, on, off;
    logic [NELEC-1:0] a, b;
  } cfg_t;

  typedef struct {
    string name;
    cfg_t  c;
    int    k;
    obs_t  e;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];
  vec_t tbl[$];

  function automatic cfg_t mkcfg(int period, int ph, int amp, int rf, int on, int off,
                                 logic [NELEC-1:0] a, logic [NELEC-1:0] b);
    cfg_t c;
    c.period = period; c.ph = ph; c.amp = amp; c.rf = rf; c.on = on; c.off = off; c.a = a; c.b = b;
    return c;
  endfunction

  function automatic logic fault_of(cfg_t c);
`ifdef ASKA_NPG_OVERLAP_CHK_EN
    return |(c.a & c.b);
`else
    return 1'b0;
`endif
  endfunction

  function automatic obs_t e_ph(cfg_t c, int dac, bit second);
    obs_t o;
    logic [NELEC-1:0] mu, md;
`ifdef ASKA_NPG_OVERLAP_CHK_EN
    mu = c.a & ~c.b;
    md = c.b & ~c.a;
`else
    mu = c.a;
    md = c.b;
`endif
    o.up  = second ? md : mu;
    o.dn  = second ? mu : md;
    o.dac = AMP_W'(dac);
    o.pa  = 1'b1;
    o.bo  = 1'b1;
    o.flt = fault_of(c);
    return o;
  endfunction

  function automatic obs_t e_sil(cfg_t c, logic pa, logic bo);
    obs_t o;
    o     = '0;
    o.pa  = pa;
    o.bo  = bo;
    o.flt = fault_of(c);
    return o;
  endfunction

  function automatic int level_of(cfg_t c, int pulse);
    int acc, l;
    if (c.rf == 0) return c.amp;
    acc = pulse * c.rf;
    if (acc > ACC_MAX) acc = ACC_MAX;
    l = acc / 16;
    return (l < c.amp) ? l : c.amp;
  endfunction

  // Expected sample stream from the enable edge on: BURST_START, pulses spaced max(period, length), OFF gap.
  task automatic build_trace(cfg_t c, int n);
    int len, per, lvl;
    exp_q.delete();
    len = 2 * c.ph * PH_UNIT + GAP_CYC;
    per = (c.period > len) ? c.period : len;
    while (exp_q.size() < n) begin
      exp_q.push_back(e_sil(c, 1'b0, 1'b1));
      for (int p = 1; (c.on == 0 || p <= c.on) && exp_q.size() < n; p++) begin
        lvl = level_of(c, p);
        repeat (c.ph * PH_UNIT) exp_q.push_back(e_ph(c, lvl, 1'b0));
        repeat (GAP_CYC)        exp_q.push_back(e_sil(c, 1'b1, 1'b1));
        repeat (c.ph * PH_UNIT) exp_q.push_back(e_ph(c, lvl, 1'b1));
        repeat (per - len)      exp_q.push_back(e_sil(c, 1'b0, 1'b1));
      end
      repeat (c.off * c.period) exp_q.push_back(e_sil(c, 1'b0, 1'b0));
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.up  = bus.up_switches;
    o.dn  = bus.down_switches;
    o.dac = bus.DAC;
    o.pa  = bus.pulse_active;
    o.bo  = bus.burst_on;
`ifdef ASKA_NPG_OVERLAP_CHK_EN
    o.flt = bus.ele_fault;
`else
    o.flt = 1'b0;
`endif
    return o;
  endfunction

  task automatic check(string name, obs_t e);
    obs_t a;
    a = sample();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got up=%h dn=%h dac=%0d pa=%b bo=%b flt=%b, want up=%h dn=%h dac=%0d pa=%b bo=%b flt=%b",
               name, a.up, a.dn, a.dac, a.pa, a.bo, a.flt, e.up, e.dn, e.dac, e.pa, e.bo, e.flt);
    end
  endtask

  task automatic skip(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn     = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Leaves the bench at sample k=0, i.e. just after the BURST_START edge.
  task automatic start(cfg_t c);
    bus.period      = PER_W'(c.period);
    bus.phase_dur   = PH_W'(c.ph);
    bus.amplitude   = AMP_W'(c.amp);
    bus.ramp_factor = RF_W'(c.rf);
    bus.on_pulses   = ON_W'(c.on);
    bus.off_pulses  = OFF_W'(c.off);
    bus.ele_a       = c.a;
    bus.ele_b       = c.b;
    bus.enable      = 1'b1;
    @(negedge clk);
  endtask

  task automatic addv(string name, cfg_t c, int k, obs_t e);
    vec_t v;
    v.name = name; v.c = c; v.k = k; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    cfg_t cb, cr, cu, crb, cs, cn, co, cs1, cs2, c, c2;

    cb  = mkcfg(400, 2, 20, 0,    0, 0, 32'h1, 32'h2);
    cr  = mkcfg(20,  2, 10, 32,   0, 0, 32'h1, 32'h2);
    cu  = mkcfg(20,  2, 20, 0,    3, 2, 32'h1, 32'h2);
    crb = mkcfg(20,  2, 10, 32,   2, 1, 32'h1, 32'h2);
    cs  = mkcfg(3,   2, 20, 0,    0, 0, 32'h1, 32'h2);
    cn  = mkcfg(10,  1, 20, 0,    2, 0, 32'h1, 32'h2);
    co  = mkcfg(400, 2, 20, 0,    0, 0, 32'h3, 32'h6);
    cs1 = mkcfg(20,  1, 63, 1023, 0, 0, 32'h1, 32'h2);
    cs2 = mkcfg(20,  1, 63, 1000, 0, 0, 32'h1, 32'h2);

    addv("burst_start",    cb, 0,   e_sil(cb, 0, 1));
    addv("basic_ph1",      cb, 1,   e_ph(cb, 20, 0));
    addv("basic_ph1_last", cb, 2,   e_ph(cb, 20, 0));
    addv("basic_gap",      cb, 3,   e_sil(cb, 1, 1));
    addv("basic_ph2",      cb, 4,   e_ph(cb, 20, 1));
    addv("basic_ph2_last", cb, 5,   e_ph(cb, 20, 1));
    addv("basic_wait",     cb, 6,   e_sil(cb, 0, 1));
    addv("basic_wait_end", cb, 400, e_sil(cb, 0, 1));
    addv("basic_repeat",   cb, 401, e_ph(cb, 20, 0));
    addv("ramp_p1",        cr, 1,   e_ph(cr, 2, 0));
    addv("ramp_p2",        cr, 21,  e_ph(cr, 4, 0));
    addv("ramp_p2_ph2",    cr, 24,  e_ph(cr, 4, 1));
    addv("ramp_p3",        cr, 41,  e_ph(cr, 6, 0));
    addv("ramp_p5",        cr, 81,  e_ph(cr, 10, 0));
    addv("ramp_p7_sat",    cr, 121, e_ph(cr, 10, 0));
    addv("burst_p3",       cu, 41,  e_ph(cu, 20, 0));
    addv("burst_last_wait",cu, 60,  e_sil(cu, 0, 1));
    addv("burst_off_first",cu, 61,  e_sil(cu, 0, 0));
    addv("burst_off_last", cu, 100, e_sil(cu, 0, 0));
    addv("burst_restart",  cu, 101, e_sil(cu, 0, 1));
    addv("burst_next_p1",  cu, 102, e_ph(cu, 20, 0));
    addv("rburst_p2",      crb, 21, e_ph(crb, 4, 0));
    addv("rburst_off",     crb, 41, e_sil(crb, 0, 0));
    addv("rburst_bs",      crb, 61, e_sil(crb, 0, 1));
    addv("rburst_acc_rst", crb, 62, e_ph(crb, 2, 0));
    addv("short_per_ph2",  cs, 5,   e_ph(cs, 20, 1));
    addv("short_per_next", cs, 6,   e_ph(cs, 20, 0));
    addv("short_per_p3",   cs, 11,  e_ph(cs, 20, 0));
    addv("nooff_bs",       cn, 21,  e_sil(cn, 0, 1));
    addv("nooff_p1",       cn, 22,  e_ph(cn, 20, 0));
    addv("overlap_ph1",    co, 1,   e_ph(co, 20, 0));
    addv("overlap_ph2",    co, 4,   e_ph(co, 20, 1));
    addv("acc_sat_p1",     cs1, 1,  e_ph(cs1, 63, 0));
    addv("acc_62_p1",      cs2, 1,  e_ph(cs2, 62, 0));
    addv("acc_clip_p2",    cs2, 21, e_ph(cs2, 63, 0));

    resetn = 1'b0;
    bus.enable = 1'b0; bus.amplitude = '0; bus.period = '0; bus.phase_dur = '0;
    bus.ramp_factor = '0; bus.on_pulses = '0; bus.off_pulses = '0; bus.ele_a = '0; bus.ele_b = '0;
    skip(2);
    check("reset_state", '0);
    resetn = 1'b1;
    skip(1);
    check("idle_no_enable", '0);

    foreach (tbl[i]) begin
      do_reset();
      start(tbl[i].c);
      skip(tbl[i].k);
      check(tbl[i].name, tbl[i].e);
    end

    // Enable drops during PH1: pulse completes in full, then IDLE.
    c = mkcfg(400, 3, 20, 0, 0, 0, 32'h1, 32'h2);
    do_reset();
    start(c);
    skip(1);
    bus.enable = 1'b0;
    skip(3); check("dis_gap",      e_sil(c, 1, 1));
    skip(1); check("dis_ph2",      e_ph(c, 20, 1));
    skip(2); check("dis_ph2_last", e_ph(c, 20, 1));
    skip(1); check("dis_idle",     e_sil(c, 0, 0));

    // Enable drops in WAIT: IDLE on the next edge.
    do_reset();
    start(cb);
    skip(10); check("wait_before_dis", e_sil(cb, 0, 1));
    bus.enable = 1'b0;
    skip(1);  check("wait_dis_idle",   e_sil(cb, 0, 0));

    // Reset mid-PH2, then restart with enable still high.
    do_reset();
    start(cb);
    skip(4); check("pre_rst_ph2", e_ph(cb, 20, 1));
    resetn = 1'b0;
    skip(1); check("rst_mid_ph2", '0);
    resetn = 1'b1;
    skip(1); check("rst_restart_bs",  e_sil(cb, 0, 1));
    skip(1); check("rst_restart_ph1", e_ph(cb, 20, 0));

    // Amplitude change mid-burst takes effect only at the next burst.
    c  = mkcfg(20, 2, 20, 0, 2, 0, 32'h1, 32'h2);
    c2 = mkcfg(20, 2, 30, 0, 2, 0, 32'h1, 32'h2);
    do_reset();
    start(c);
    skip(1);  check("amp_old_p1", e_ph(c, 20, 0));
    bus.amplitude = AMP_W'(30);
    skip(20); check("amp_old_p2", e_ph(c, 20, 0));
    skip(20); check("amp_bs",     e_sil(c, 0, 1));
    skip(1);  check("amp_new_p1", e_ph(c2, 30, 0));

    for (int it = 0; it < 12; it++) begin
      c.period = $urandom_range(1, 40);
      c.ph     = $urandom_range(1, 7);
      c.amp    = $urandom_range(1, 63);
      c.rf     = $urandom_range(0, 1023);
      if (c.rf < 200) c.rf = 0;
      else if (c.rf < 500) c.rf = c.rf / 16;
      c.on     = $urandom_range(0, 4);
      c.off    = $urandom_range(0, 3);
      c.a      = $urandom;
      c.b      = $urandom;
      if (it % 3 == 0) c.b = c.b & ~c.a;
      build_trace(c, 150);
      do_reset();
      start(c);
      for (int k = 0; k < 150; k++) begin
        check($sformatf("rand%0d_k%0d", it, k), exp_q[k]);
        skip(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
